// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared op codes, state encoding and constants for div_ctrl
package div_ctrl_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_e;

    function automatic logic [31:0] pick_result(input logic [1:0] op,
                                                input logic [31:0] quot,
                                                input logic [31:0] rem);
        return ((op == OP_REM) || (op == OP_REMU)) ? rem : quot;
    endfunction

endpackage

// File: rtl/div_ctrl_special.sv
// rtl/div_ctrl_special.sv - flags divide corner cases and produces their results
module div_ctrl_special
    import div_ctrl_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        special_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic is_signed;

    always_comb begin
        is_signed = (op_i == OP_DIV) || (op_i == OP_REM);
        special_o = 1'b0;
        quot_o    = 32'd0;
        rem_o     = 32'd0;
        if (rs2_i == 32'd0) begin
            special_o = 1'b1;
            quot_o    = ALL_ONES;
            rem_o     = rs1_i;
        end else if (is_signed && (rs1_i == INT_MIN) && (rs2_i == ALL_ONES)) begin
            special_o = 1'b1;
            quot_o    = INT_MIN;
        end else if (rs1_i == 32'd0) begin
            special_o = 1'b1;
        end
    end

endmodule

// File: rtl/srt_8_div.sv
// rtl/srt_8_div.sv - behavioural stand-in for the shared radix-8 SRT divider
// Results follow the operands combinationally; mulfinish pulses after a
// normalization-dependent latency of 2..10 cycles counted from start.
module srt_8_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign_define,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        mulfinish
);

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [5:0]  nbits;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    always_comb begin
        a_neg = sign_define && dividend_i[31];
        b_neg = sign_define && divisor_i[31];
        a_mag = a_neg ? (~dividend_i + 32'd1) : dividend_i;
        b_mag = b_neg ? (~divisor_i + 32'd1) : divisor_i;
        q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag = (b_mag == 32'd0) ? a_mag : (a_mag % b_mag);
        quotient_o  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        remainder_o = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Significant dividend bits set how many radix-8 steps are needed.
    always_comb begin
        nbits = 6'd0;
        for (int i = 0; i < 32; i++) begin
            if (a_mag[i]) begin
                nbits = 6'(i + 1);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = nbits[5:2] + 4'd1;
        end else if (run_q) begin
            if (cnt_q == 4'd0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    assign mulfinish = run_q && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequencing controller for the shared SRT divider
// Optional result cache enabled by defining DIV_CTRL_RESULT_CACHE_EN.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [DW-1:0]    req_rs1_i,
    input  logic [DW-1:0]    req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [DW-1:0]    resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);

    state_e state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [DW-1:0]    rs1_q, rs1_d, rs2_q, rs2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [DW-1:0]    resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic          accept, quick, div_done_ok;
    logic          sp_special;
    logic [DW-1:0] sp_quot, sp_rem;
    logic          div_start, div_finish, sign_define;
    logic [DW-1:0] div_quot, div_rem;
    logic          cache_hit;
    logic [DW-1:0] cache_quot, cache_rem;

    div_ctrl_special u_special (
        .op_i      (req_op_i),
        .rs1_i     (req_rs1_i),
        .rs2_i     (req_rs2_i),
        .special_o (sp_special),
        .quot_o    (sp_quot),
        .rem_o     (sp_rem)
    );

    assign sign_define = (op_q != OP_DIVU) && (op_q != OP_REMU);

    // Operands come straight from the latched copy so they stay put through DRAIN.
    srt_8_div u_div (
        .clk         (clk),
        .rst_n       (~rst),
        .start       (div_start),
        .sign_define (sign_define),
        .dividend_i  (rs1_q),
        .divisor_i   (rs2_q),
        .quotient_o  (div_quot),
        .remainder_o (div_rem),
        .mulfinish   (div_finish)
    );

    assign accept      = req_valid_i && req_ready_o && !flush_i;
    assign div_done_ok = (state_q == ST_WAIT) && div_finish && !flush_i;
    assign quick       = sp_special || cache_hit;

`ifdef DIV_CTRL_RESULT_CACHE_EN
    logic          c_valid_q, c_valid_d, c_sign_q, c_sign_d;
    logic [DW-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_quot_q, c_quot_d, c_rem_q, c_rem_d;

    assign cache_hit  = c_valid_q && (c_rs1_q == req_rs1_i) && (c_rs2_q == req_rs2_i) &&
                        (c_sign_q == ((req_op_i != OP_DIVU) && (req_op_i != OP_REMU)));
    assign cache_quot = c_quot_q;
    assign cache_rem  = c_rem_q;

    always_comb begin
        c_valid_d = c_valid_q;
        c_sign_d  = c_sign_q;
        c_rs1_d   = c_rs1_q;
        c_rs2_d   = c_rs2_q;
        c_quot_d  = c_quot_q;
        c_rem_d   = c_rem_q;
        if (div_done_ok) begin
            c_valid_d = 1'b1;
            c_sign_d  = sign_define;
            c_rs1_d   = rs1_q;
            c_rs2_d   = rs2_q;
            c_quot_d  = div_quot;
            c_rem_d   = div_rem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid_q <= 1'b0;
            c_sign_q  <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_quot_q  <= '0;
            c_rem_q   <= '0;
        end else begin
            c_valid_q <= c_valid_d;
            c_sign_q  <= c_sign_d;
            c_rs1_q   <= c_rs1_d;
            c_rs2_q   <= c_rs2_d;
            c_quot_q  <= c_quot_d;
            c_rem_q   <= c_rem_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_quot = '0;
    assign cache_rem  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            rs1_q       <= '0;
            rs2_q       <= '0;
            tag_q       <= '0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            tag_q       <= tag_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = quick ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = flush_i ? ST_DRAIN : ST_WAIT;
            // A flush coinciding with mulfinish needs no drain: the divider is already done.
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = div_finish ? ST_IDLE : ST_DRAIN;
                end else if (div_finish) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  if (flush_i || resp_ready_i) state_d = ST_IDLE;
            ST_DRAIN: if (div_finish) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        tag_d       = tag_q;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;
        if (accept) begin
            op_d  = req_op_i;
            rs1_d = req_rs1_i;
            rs2_d = req_rs2_i;
            tag_d = req_tag_i;
            if (quick) begin
                resp_data_d = sp_special ? pick_result(req_op_i, sp_quot, sp_rem)
                                         : pick_result(req_op_i, cache_quot, cache_rem);
                resp_tag_d  = req_tag_i;
            end
        end else if (div_done_ok) begin
            resp_data_d = pick_result(op_q, div_quot, div_rem);
            resp_tag_d  = tag_q;
        end
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE) && !flush_i;
        resp_valid_o = (state_q == ST_RESP);
        busy_o       = (state_q != ST_IDLE);
        div_start    = (state_q == ST_ISSUE);
    end

    assign resp_data_o = resp_data_q;
    assign resp_tag_o  = resp_tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl (vector table plus random ops)
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_rs1 = '0, req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        resp_valid_o;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_tag_o;
    logic        busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic        m_valid = 1'b0;
    logic        m_sign;
    logic [31:0] m_a, m_b;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_tag_i    (req_tag),
        .flush_i      (flush),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data_o),
        .resp_tag_o   (resp_tag_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        return (b == 0) || (a == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic cache_hit(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef DIV_CTRL_RESULT_CACHE_EN
        return m_valid && (m_a == a) && (m_b == b) && (m_sign == !op[0]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [4:0] tag, input int hold,
                         input string nm);
        logic quick;
        int start_k, fin_k, resp_k, bad;
        logic [31:0] d0;
        logic [4:0] t0;
        quick = is_special(op, a, b) || cache_hit(op, a, b);
        resp_ready = (hold == 0);
        req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag; req_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        start_k = 0; fin_k = 0; resp_k = 0;
        for (int k = 1; k <= 200 && resp_k == 0; k++) begin
            @(negedge clk);
            if (dut.div_start && start_k == 0) start_k = k;
            if (dut.div_finish) fin_k = k;
            if (resp_valid_o) resp_k = k;
        end
        chk({nm, "_seen"}, 32'(resp_k != 0), 32'd1);
        chk({nm, "_data"}, resp_data_o, exp);
        chk({nm, "_tag"}, 32'(resp_tag_o), 32'(tag));
        if (quick) begin
            chk({nm, "_lat"}, 32'(resp_k), 32'd1);
            chk({nm, "_nostart"}, 32'(start_k), 32'd0);
        end else begin
            chk({nm, "_start"}, 32'(start_k), 32'd1);
            chk({nm, "_lat"}, 32'(resp_k), 32'(fin_k + 1));
            m_valid = 1'b1; m_a = a; m_b = b; m_sign = !op[0];
        end
        if (hold > 0) begin
            d0 = resp_data_o; t0 = resp_tag_o; bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!resp_valid_o || resp_data_o !== d0 || resp_tag_o !== t0 || req_ready_o)
                    bad++;
            end
            chk({nm, "_hold"}, 32'(bad), 32'd0);
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({nm, "_idle"}, 32'(busy_o), 32'd0);
        resp_ready = 1'b1;
    endtask

    vec_t vecs[15];

    initial begin
        int seen_resp, busy_fin, fin_seen, rdy_bad;
        logic [1:0] op;
        logic [31:0] a, b;

        vecs[0]  = '{2'b00, 32'd100, 32'd7, 32'd14};
        vecs[1]  = '{2'b10, 32'd100, 32'd7, 32'd2};
        vecs[2]  = '{2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE};
        vecs[3]  = '{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b11, 32'd5, 32'd0, 32'd5};
        vecs[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[7]  = '{2'b00, 32'd1000, 32'd3, 32'd333};
        vecs[8]  = '{2'b10, 32'd1000, 32'd3, 32'd1};
        vecs[9]  = '{2'b01, 32'd1000, 32'd3, 32'd333};
        vecs[10] = '{2'b00, 32'd0, 32'd5, 32'd0};
        vecs[11] = '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        vecs[12] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        vecs[13] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[14] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_data", resp_data_o, 32'd0);
        chk("rst_tag", 32'(resp_tag_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 15; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 5'(i + 3), 0, $sformatf("vec%0d", i));

        // Flush while the divider is running: no response, busy until mulfinish.
        req_op = 2'b00; req_rs1 = 32'h7FFF_FFFF; req_rs2 = 32'd3; req_tag = 5'd21; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen_resp = 0; busy_fin = 0; fin_seen = 0; rdy_bad = 0;
        for (int k = 0; k < 60 && fin_seen == 0; k++) begin
            @(negedge clk);
            if (resp_valid_o) seen_resp++;
            if (req_ready_o) rdy_bad++;
            if (dut.div_finish) begin
                fin_seen = 1;
                busy_fin = busy_o;
            end
        end
        @(negedge clk);
        chk("flush_finish", 32'(fin_seen), 32'd1);
        chk("flush_noresp", 32'(seen_resp + 32'(resp_valid_o)), 32'd0);
        chk("flush_busy_held", 32'(busy_fin + rdy_bad), 32'd1);
        chk("flush_idle", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        do_op(2'b01, 32'd9, 32'd3, 32'd3, 5'd22, 0, "post_flush");

        do_op(2'b10, 32'd100, 32'd7, 32'd2, 5'd9, 10, "bp");

        // Flush drops a pending response.
        resp_ready = 1'b0;
        req_op = 2'b01; req_rs1 = 32'd5; req_rs2 = 32'd0; req_tag = 5'd30; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("fresp_valid", 32'(resp_valid_o), 32'd1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("fresp_noready", 32'(req_ready_o), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("fresp_dropped", 32'(resp_valid_o), 32'd0);
        chk("fresp_idle", 32'(busy_o), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-operation.
        req_op = 2'b00; req_rs1 = 32'h7FFF_FFFF; req_rs2 = 32'd5; req_tag = 5'd1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_valid", 32'(resp_valid_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_valid = 1'b0;
        do_op(2'b00, 32'd100, 32'd7, 32'd14, 5'd2, 0, "post_rst");

        a = 32'd1; b = 32'd1;
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'd0; b = $urandom; end
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: ;
                4: begin a = $urandom_range(0, 5000); b = $urandom_range(1, 40); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            do_op(op, a, b, ref_result(op, a, b), 5'($urandom), 0, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
